// File: rtl/keypad_link_rx_pkg.sv
// Shared definitions for the keypad link receiver: FSM state encoding,
// frame field widths and the clear-key code.
package keypad_link_rx_pkg;

  localparam int DATA_W = 3;
  localparam int KEY_W  = 4;

  localparam logic [KEY_W-1:0] CLEAR_KEY = 4'hF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SET0 = 3'd1,
    LOW0 = 3'd2,
    GAP  = 3'd3,
    SET1 = 3'd4,
    LOW1 = 3'd5
  } rx_state_e;

  // Counter width needed to hold the larger of the two count limits.
  function automatic int cnt_width(input int settle, input int timeout);
    int max_v;
    max_v = (timeout > settle) ? timeout : settle;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/keypad_link_rx_sync.sv
// Multi-bit, STAGES-deep flop synchroniser with asynchronous active-high
// reset. Intended for slowly changing, strobe-qualified buses only.
module link_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the input through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its predecessor held before this edge.
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/keypad_link_rx.sv
// Receive side of the keypad 3-data + strobe link. Rebuilds a 4-bit key
// from two strobed frames and emits key_valid / frame_err pulses.
// Optional feature macro: KEYRX_HISTORY_EN (adds the digit history port).
module keypad_link_rx
  import keypad_link_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1200000,
  parameter int HIST_DEPTH     = 8
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_d,
  input  logic              rx_ctl,
  output logic [KEY_W-1:0]  key,
  output logic              key_valid,
  output logic              frame_err,
  output logic              busy
`ifdef KEYRX_HISTORY_EN
  ,
  output logic [HIST_DEPTH*KEY_W-1:0] history
`endif
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [DATA_W-1:0] s_d;
  logic              s_ctl;

  link_sync #(
    .WIDTH  (DATA_W + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (hwclk),
    .rst (reset),
    .d_i ({rx_ctl, rx_d}),
    .q_o ({s_ctl, s_d})
  );

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              hi_q, hi_d;
  logic              bad_q, bad_d;
  logic              ctl_prev_q;
  logic              ctl_rise;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [KEY_W-1:0]  key_new;
  logic              key_valid_q, key_valid_d;
  logic              frame_err_q, frame_err_d;
`ifdef KEYRX_HISTORY_EN
  logic [HIST_DEPTH*KEY_W-1:0] hist_q, hist_d;
`endif

  assign ctl_rise = s_ctl & ~ctl_prev_q;
  // Saturating increment: a stuck link can never wrap the counter.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign key_new  = {hi_q, lo_q};

  // Next-state and output decode for the frame reassembly FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    bad_d       = bad_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef KEYRX_HISTORY_EN
    hist_d      = hist_q;
`endif
    case (state_q)
      IDLE: begin
        if (ctl_rise) begin
          state_d = SET0;
          cnt_d   = '0;
        end
      end
      SET0: begin
        if (!s_ctl) begin
          frame_err_d = 1'b1;          // runt strobe
          state_d     = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          lo_d    = s_d;
          state_d = LOW0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOW0: begin
        if (!s_ctl) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (ctl_rise) begin
          state_d = SET1;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SET1: begin
        if (!s_ctl) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          hi_d    = s_d[0];
          bad_d   = |s_d[DATA_W-1:1];
          // Upper bits of frame 1 must be zero; flag now, drain the strobe.
          frame_err_d = |s_d[DATA_W-1:1];
          state_d = LOW1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOW1: begin
        if (!s_ctl) begin
          state_d = IDLE;
          if (!bad_q) begin
            key_d       = key_new;
            key_valid_d = 1'b1;
`ifdef KEYRX_HISTORY_EN
            if (key_new == CLEAR_KEY) begin
              hist_d = '0;
            end else begin
              hist_d = {hist_q[HIST_DEPTH*KEY_W-KEY_W-1:0], key_new};
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lo_q        <= '0;
      hi_q        <= 1'b0;
      bad_q       <= 1'b0;
      ctl_prev_q  <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      bad_q       <= bad_d;
      ctl_prev_q  <= s_ctl;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef KEYRX_HISTORY_EN
  // Digit history shift register, newest digit in the low nibble.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign history = hist_q;
`endif

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_link_rx.sv
// Self-checking bench for keypad_link_rx with a key scoreboard queue.
module tb_keypad_link_rx;

  localparam int SYNC_STAGES    = 2;
  localparam int SETTLE_CYCLES  = 4;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int HIST_DEPTH     = 8;

  logic       hwclk;
  logic       reset;
  logic [2:0] rx_d;
  logic       rx_ctl;
  logic [3:0] key;
  logic       key_valid;
  logic       frame_err;
  logic       busy;
`ifdef KEYRX_HISTORY_EN
  logic [31:0] history;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int kv_cnt  = 0;
  int err_cnt = 0;
  logic [3:0] exp_q[$];

  keypad_link_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .HIST_DEPTH     (HIST_DEPTH)
  ) dut (
    .hwclk     (hwclk),
    .reset     (reset),
    .rx_d      (rx_d),
    .rx_ctl    (rx_ctl),
    .key       (key),
    .key_valid (key_valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef KEYRX_HISTORY_EN
    ,
    .history   (history)
`endif
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  // Scoreboard monitor: every key_valid pops one expected key.
  always @(negedge hwclk) begin
    if (frame_err) err_cnt++;
    if (key_valid) begin
      kv_cnt++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: key_valid with key=%h, none expected", key);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key !== e || frame_err !== 1'b0)
          $display("FAIL sb_key: key=%h frame_err=%b, expected key=%h frame_err=0", key, frame_err, e);
        else
          n_pass++;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic drive_frame(input logic [2:0] d, input int hi, input int lo);
    @(negedge hwclk);
    rx_d   = d;
    rx_ctl = 1'b1;
    repeat (hi) @(negedge hwclk);
    rx_ctl = 1'b0;
    repeat (lo) @(negedge hwclk);
  endtask

  // Count negedges after the current one until the chosen pulse appears.
  task automatic measure(input bit want_err, input int bound, output int k);
    k = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge hwclk);
      if ((want_err ? frame_err : key_valid) === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge hwclk);
    reset  = 1'b1;
    rx_ctl = 1'b0;
    rx_d   = 3'b000;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic send_symbol(input logic [3:0] k);
    int lat;
    int kv0, err0;
    kv0  = kv_cnt;
    err0 = err_cnt;
    exp_q.push_back(k);
    drive_frame(k[2:0], 10, 10);
    drive_frame({2'b00, k[3]}, 10, 0);
    measure(1'b0, 20, lat);
    n_total++;
    if (lat !== SYNC_STAGES + 1)
      $display("FAIL latency_%h: got %0d cycles, expected %0d", k, lat, SYNC_STAGES + 1);
    else
      n_pass++;
    wait_cycles(10);
    n_total++;
    if (key !== k || kv_cnt - kv0 !== 1 || err_cnt - err0 !== 0 || busy !== 1'b0)
      $display("FAIL symbol_%h: key=%h pulses=%0d errs=%0d busy=%b, expected key=%h pulses=1 errs=0 busy=0",
               k, key, kv_cnt - kv0, err_cnt - err0, busy, k);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    rx_ctl = 1'b0;
    rx_d   = 3'b000;
    wait_cycles(3);
    n_total++;
    if ({key, key_valid, frame_err, busy} !== 7'b0)
      $display("FAIL reset_outputs: key=%h kv=%b fe=%b busy=%b, expected all 0", key, key_valid, frame_err, busy);
    else
      n_pass++;
`ifdef KEYRX_HISTORY_EN
    n_total++;
    if (history !== 32'h0)
      $display("FAIL reset_history: got %h, expected 0", history);
    else
      n_pass++;
`endif
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_keys();
    send_symbol(4'h5);
    send_symbol(4'h9);
  endtask

  task automatic test_runt();
    int kv0, err0;
    kv0  = kv_cnt;
    err0 = err_cnt;
    drive_frame(3'b111, 2, 10);
    n_total++;
    if (err_cnt - err0 !== 1 || kv_cnt - kv0 !== 0 || key !== 4'h9 || busy !== 1'b0)
      $display("FAIL runt: errs=%0d pulses=%0d key=%h busy=%b, expected errs=1 pulses=0 key=9 busy=0",
               err_cnt - err0, kv_cnt - kv0, key, busy);
    else
      n_pass++;
  endtask

  task automatic test_timeout();
    int lat;
    int kv0;
    kv0 = kv_cnt;
    drive_frame(3'b011, 10, 0);
    n_total++;
    if (busy !== 1'b1)
      $display("FAIL timeout_busy: busy=%b during frame 0, expected 1", busy);
    else
      n_pass++;
    measure(1'b1, 300, lat);
    n_total++;
    if (lat !== SYNC_STAGES + 1 + TIMEOUT_CYCLES)
      $display("FAIL timeout_cycle: frame_err after %0d cycles, expected %0d", lat, SYNC_STAGES + 1 + TIMEOUT_CYCLES);
    else
      n_pass++;
    wait_cycles(1);
    n_total++;
    if (busy !== 1'b0 || kv_cnt - kv0 !== 0)
      $display("FAIL timeout_idle: busy=%b pulses=%0d, expected busy=0 pulses=0", busy, kv_cnt - kv0);
    else
      n_pass++;
    wait_cycles(5);
    send_symbol(4'h3);
  endtask

  task automatic test_bad_and_reset();
    int kv0, err0;
    kv0  = kv_cnt;
    err0 = err_cnt;
    drive_frame(3'b010, 10, 10);
    drive_frame(3'b110, 10, 20);
    n_total++;
    if (err_cnt - err0 !== 1 || kv_cnt - kv0 !== 0 || key !== 4'h3 || busy !== 1'b0)
      $display("FAIL bad_frame1: errs=%0d pulses=%0d key=%h busy=%b, expected errs=1 pulses=0 key=3 busy=0",
               err_cnt - err0, kv_cnt - kv0, key, busy);
    else
      n_pass++;
    drive_frame(3'b100, 10, 10);
    n_total++;
    if (busy !== 1'b1)
      $display("FAIL gap_busy: busy=%b in GAP, expected 1", busy);
    else
      n_pass++;
    reset = 1'b1;
    wait_cycles(2);
    n_total++;
    if ({key, key_valid, frame_err, busy} !== 7'b0)
      $display("FAIL midgap_reset: key=%h kv=%b fe=%b busy=%b, expected all 0", key, key_valid, frame_err, busy);
    else
      n_pass++;
    reset = 1'b0;
    kv0  = kv_cnt;
    err0 = err_cnt;
    wait_cycles(TIMEOUT_CYCLES + 50);
    n_total++;
    if (kv_cnt - kv0 !== 0 || err_cnt - err0 !== 0 || key !== 4'h0)
      $display("FAIL after_reset: pulses=%0d errs=%0d key=%h, expected 0 0 0", kv_cnt - kv0, err_cnt - err0, key);
    else
      n_pass++;
  endtask

  task automatic test_back_to_back();
    int kv0;
    kv0 = kv_cnt;
    exp_q.push_back(4'hA);
    exp_q.push_back(4'h6);
    drive_frame(3'b010, 10, 10);
    drive_frame(3'b001, 10, 0);
    drive_frame(3'b110, 10, 10);
    drive_frame(3'b000, 10, 20);
    n_total++;
    if (kv_cnt - kv0 !== 2 || key !== 4'h6)
      $display("FAIL back_to_back: pulses=%0d key=%h, expected pulses=2 key=6", kv_cnt - kv0, key);
    else
      n_pass++;
  endtask

`ifdef KEYRX_HISTORY_EN
  task automatic test_history();
    int kv0;
    apply_reset();
    send_symbol(4'h1);
    send_symbol(4'h2);
    send_symbol(4'h3);
    n_total++;
    if (history !== 32'h00000123)
      $display("FAIL history_shift: got %h, expected 00000123", history);
    else
      n_pass++;
    kv0 = kv_cnt;
    send_symbol(4'hF);
    n_total++;
    if (history !== 32'h0 || kv_cnt - kv0 !== 1)
      $display("FAIL history_clear: history=%h pulses=%0d, expected 0 and 1", history, kv_cnt - kv0);
    else
      n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_keys();
    test_runt();
    test_timeout();
    test_bad_and_reset();
    test_back_to_back();
`ifdef KEYRX_HISTORY_EN
    test_history();
`endif
    wait_cycles(5);
    n_total++;
    if (exp_q.size() !== 0)
      $display("FAIL sb_drain: %0d expected keys never received, expected 0", exp_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
